// File: rtl/imm_encoder.sv
// imm_encoder: scatters a signed immediate into RISC-V I/S/B/J instruction fields,
// flags range/alignment errors and queues {Instr, Err} in a 2-entry output FIFO.
module imm_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  ImmSrc,
   input  logic [31:0] Imm,
   input  logic [31:0] Base,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Instr,
   output logic        Err,
   output logic [15:0] ErrCount
);

   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
   localparam logic [1:0] FMT_B = 2'b10;
   localparam logic [1:0] FMT_J = 2'b11;

   function automatic logic [31:0] f_imm_mask(input logic [1:0] src);
      logic [31:0] m;
      case (src)
         FMT_I:   m = 32'hFFF0_0000;
         FMT_S:   m = 32'hFE00_0F80;
         FMT_B:   m = 32'hFE00_0F80;
         FMT_J:   m = 32'hFFFF_F000;
         default: m = 32'h0000_0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] f_imm_field(input logic [1:0] src, input logic [31:0] imm);
      logic [31:0] f;
      case (src)
         FMT_I:   f = {imm[11:0], 20'h00000};
         FMT_S:   f = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
         FMT_B:   f = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
         FMT_J:   f = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
         default: f = 32'h0000_0000;
      endcase
      return f;
   endfunction

   // Upper bits must be a pure sign extension; B/J offsets must also be halfword aligned.
   function automatic logic f_imm_err(input logic [1:0] src, input logic [31:0] imm);
      logic e;
      case (src)
         FMT_I, FMT_S: e = ~((&imm[31:11]) | ~(|imm[31:11]));
         FMT_B:        e = ~((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
         FMT_J:        e = ~((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
         default:      e = 1'b1;
      endcase
      return e;
   endfunction

   logic [1:0]  r_count;
   logic [31:0] r_head_instr;
   logic        r_head_err;
   logic [31:0] r_tail_instr;
   logic        r_tail_err;
   logic [15:0] r_err_count;
   logic        r_in_ready;
   logic        r_out_valid;

   logic        w_push;
   logic        w_pop;
   logic [31:0] w_instr;
   logic        w_err;
   logic [1:0]  w_count_nxt;
   logic [31:0] w_head_instr_nxt;
   logic        w_head_err_nxt;
   logic [31:0] w_tail_instr_nxt;
   logic        w_tail_err_nxt;
   logic [15:0] w_err_count_nxt;

   // Handshakes and encoding of the word currently offered
   always_comb begin
      w_push  = in_valid & r_in_ready;
      w_pop   = r_out_valid & out_ready;
      w_instr = (Base & ~f_imm_mask(ImmSrc)) | f_imm_field(ImmSrc, Imm);
      w_err   = f_imm_err(ImmSrc, Imm);
   end

   // FIFO next state; the head register is the output, so it holds its value when emptied
   always_comb begin
      w_count_nxt      = r_count;
      w_head_instr_nxt = r_head_instr;
      w_head_err_nxt   = r_head_err;
      w_tail_instr_nxt = r_tail_instr;
      w_tail_err_nxt   = r_tail_err;
      case (r_count)
         2'd0: begin
            if (w_push) begin
               w_head_instr_nxt = w_instr;
               w_head_err_nxt   = w_err;
               w_count_nxt      = 2'd1;
            end else begin
               w_count_nxt = 2'd0;
            end
         end
         2'd1: begin
            if (w_push && w_pop) begin
               w_head_instr_nxt = w_instr;
               w_head_err_nxt   = w_err;
            end else if (w_push) begin
               w_tail_instr_nxt = w_instr;
               w_tail_err_nxt   = w_err;
               w_count_nxt      = 2'd2;
            end else if (w_pop) begin
               w_count_nxt = 2'd0;
            end else begin
               w_count_nxt = 2'd1;
            end
         end
         2'd2: begin
            if (w_pop) begin
               w_head_instr_nxt = r_tail_instr;
               w_head_err_nxt   = r_tail_err;
               w_count_nxt      = 2'd1;
            end else begin
               w_count_nxt = 2'd2;
            end
         end
         default: w_count_nxt = 2'd0;
      endcase
      if (w_push && w_err && (r_err_count != 16'hFFFF)) begin
         w_err_count_nxt = r_err_count + 16'd1;
      end else begin
         w_err_count_nxt = r_err_count;
      end
   end

   // State registers; handshake flags are registered copies of the next occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count      <= 2'd0;
         r_head_instr <= 32'h0000_0000;
         r_head_err   <= 1'b0;
         r_tail_instr <= 32'h0000_0000;
         r_tail_err   <= 1'b0;
         r_err_count  <= 16'h0000;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
      end else begin
         r_count      <= w_count_nxt;
         r_head_instr <= w_head_instr_nxt;
         r_head_err   <= w_head_err_nxt;
         r_tail_instr <= w_tail_instr_nxt;
         r_tail_err   <= w_tail_err_nxt;
         r_err_count  <= w_err_count_nxt;
         r_in_ready   <= (w_count_nxt != 2'd2);
         r_out_valid  <= (w_count_nxt != 2'd0);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Instr     = r_head_instr;
   assign Err       = r_head_err;
   assign ErrCount  = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus a randomized sweep
// against a queue-based reference model and a decode-side sign extender.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ImmSrc;
   logic [31:0] Imm;
   logic [31:0] Base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Instr;
   logic        Err;
   logic [15:0] ErrCount;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  src;
      logic [31:0] imm;
   } ent_t;

   ent_t        q[$];
   logic [15:0] m_errcnt;

   imm_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ImmSrc(ImmSrc), .Imm(Imm), .Base(Base), .out_valid(out_valid),
      .out_ready(out_ready), .Instr(Instr), .Err(Err), .ErrCount(ErrCount)
   );

   always #5 clk = ~clk;

   // Representable-range checks as plain signed arithmetic
   function automatic logic m_err(input logic [1:0] src, input logic [31:0] imm);
      int v;
      v = int'($signed(imm));
      case (src)
         2'b00, 2'b01: return !(v >= -2048 && v <= 2047);
         2'b10:        return !(v >= -4096 && v <= 4095) || imm[0];
         default:      return !(v >= -1048576 && v <= 1048575) || imm[0];
      endcase
   endfunction

   function automatic logic [31:0] m_encode(input logic [1:0] src, input logic [31:0] imm,
                                            input logic [31:0] base);
      logic [31:0] r;
      r = base;
      case (src)
         2'b00: r[31:20] = imm[11:0];
         2'b01: begin r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; end
         2'b10: begin r[31] = imm[12]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; r[7] = imm[11]; end
         default: begin r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12]; end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] m_decode(input logic [31:0] ins, input logic [1:0] src);
      case (src)
         2'b00:   return {{20{ins[31]}}, ins[31:20]};
         2'b01:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         2'b10:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      endcase
   endfunction

   task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] base, input logic ordy);
      in_valid  = v;
      ImmSrc    = src;
      Imm       = imm;
      Base      = base;
      out_ready = ordy;
   endtask

   // Advance the model by one edge using the currently driven inputs, then the DUT
   task automatic tick();
      ent_t e;
      logic acc;
      logic pop;
      acc = in_valid && (q.size() != 2);
      pop = (q.size() != 0) && out_ready;
      if (pop) e = q.pop_front();
      if (acc) begin
         e.src   = ImmSrc;
         e.imm   = Imm;
         e.instr = m_encode(ImmSrc, Imm, Base);
         e.err   = m_err(ImmSrc, Imm);
         q.push_back(e);
         if (e.err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 2'b00, 32'h0000_0123, 32'h0000_0093, 1'b1);
      q.delete();
      m_errcnt = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_tests++; if (Instr !== 32'h0 || Err !== 1'b0) begin n_fail++; $display("FAIL rst_head: got %h/%b want 0/0", Instr, Err); end
      n_tests++; if (ErrCount !== 16'h0) begin n_fail++; $display("FAIL rst_errcount: got %h want 0", ErrCount); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_i_type();
      drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0093, 1'b0);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_early_valid: got %b want 0", out_valid); end
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL i_latency: got %b want 1", out_valid); end
      n_tests++; if (Instr !== 32'hFFF0_0093 || Err !== 1'b0) begin n_fail++; $display("FAIL i_instr: got %h/%b want fff00093/0", Instr, Err); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      tick();
      n_tests++; if (out_valid !== 1'b0 || Instr !== 32'hFFF0_0093) begin n_fail++; $display("FAIL i_pop_hold: got %b/%h want 0/fff00093", out_valid, Instr); end
   endtask

   task automatic test_s_b();
      drive(1'b1, 2'b01, 32'h0000_0008, 32'h0011_2023, 1'b0);
      tick();
      drive(1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0020_8063, 1'b0);
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      n_tests++; if (Instr !== 32'h0011_2423 || Err !== 1'b0) begin n_fail++; $display("FAIL s_instr: got %h/%b want 00112423/0", Instr, Err); end
      tick();
      n_tests++; if (Instr !== 32'hFE20_8EE3 || Err !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b_instr: got %h/%b/%b want fe208ee3/0/1", Instr, Err, out_valid); end
      tick();
   endtask

   task automatic test_j_type();
      drive(1'b1, 2'b11, 32'h0000_0800, 32'h0000_00EF, 1'b0);
      tick();
      drive(1'b1, 2'b11, 32'hFFF0_0000, 32'h0000_00EF, 1'b0);
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      n_tests++; if (Instr !== 32'h0010_00EF || Err !== 1'b0) begin n_fail++; $display("FAIL j_instr: got %h/%b want 001000ef/0", Instr, Err); end
      tick();
      n_tests++; if (Instr !== 32'h8000_00EF || Err !== 1'b0) begin n_fail++; $display("FAIL j_min: got %h/%b want 800000ef/0", Instr, Err); end
      tick();
   endtask

   task automatic test_errors();
      drive(1'b1, 2'b00, 32'h0000_0800, 32'h0000_0093, 1'b1);
      tick();
      n_tests++; if (Instr !== 32'h8000_0093 || Err !== 1'b1 || ErrCount !== 16'd1) begin n_fail++; $display("FAIL err_i: got %h/%b/%h want 80000093/1/0001", Instr, Err, ErrCount); end
      drive(1'b1, 2'b10, 32'h0000_0003, 32'h0020_8063, 1'b1);
      tick();
      n_tests++; if (Instr !== 32'h0020_8163 || Err !== 1'b1 || ErrCount !== 16'd2) begin n_fail++; $display("FAIL err_b: got %h/%b/%h want 00208163/1/0002", Instr, Err, ErrCount); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      tick();
      force dut.r_err_count = 16'hFFFE;
      #1;
      release dut.r_err_count;
      m_errcnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b00, 32'h0001_0000, 32'h0000_0013, 1'b1);
         tick();
         n_tests++; if (ErrCount !== 16'hFFFF) begin n_fail++; $display("FAIL err_saturate[%0d]: got %h want ffff", i, ErrCount); end
      end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      tick();
   endtask

   task automatic test_backpressure();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 2'b00, i, 32'h0000_0013, 1'b0);
         tick();
      end
      n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      n_tests++; if (Instr !== 32'h0010_0013) begin n_fail++; $display("FAIL bp_first: got %h want 00100013", Instr); end
      tick();
      n_tests++; if (Instr !== 32'h0020_0013 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second: got %h/%b want 00200013/1", Instr, in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0 (third word must be dropped)", out_valid); end
      drive(1'b1, 2'b01, 32'h0000_0010, 32'h0000_0023, 1'b0);
      tick();
      drive(1'b1, 2'b01, 32'h0000_0011, 32'h0000_0023, 1'b1);
      tick();
      n_tests++; if (Instr !== 32'h0000_08A3 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pushpop: got %h/%b/%b want 000008a3/1/1", Instr, out_valid, in_ready); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pushpop_count: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 2'b00, 32'h0000_0800, 32'h0000_0093, 1'b0);
      tick();
      drive(1'b1, 2'b01, 32'h0000_0005, 32'h0000_0023, 1'b0);
      tick();
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || ErrCount !== m_errcnt) begin n_fail++; $display("FAIL mid_pre: got %b/%b/%h want 1/0/%h", out_valid, in_ready, ErrCount, m_errcnt); end
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_errcnt = 16'h0000;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ErrCount !== 16'h0) begin n_fail++; $display("FAIL mid_reset: got %b/%b/%h want 0/1/0000", out_valid, in_ready, ErrCount); end
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [31:0] imm;
      logic [31:0] dec;
      for (int c = 0; c < 600; c++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = {{20{r[11]}}, r[11:0]};
            2: imm = {{11{r[20]}}, r[20:0]};
            default: imm = {{19{r[12]}}, r[12:1], 1'b0};
         endcase
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), imm, $urandom,
               ($urandom_range(0, 2) != 0));
         n_tests++; if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_flags[%0d]: got rdy=%b vld=%b, model occupancy %0d", c, in_ready, out_valid, q.size()); end
         n_tests++; if (ErrCount !== m_errcnt) begin n_fail++; $display("FAIL rnd_errcount[%0d]: got %h want %h", c, ErrCount, m_errcnt); end
         if (q.size() != 0) begin
            n_tests++; if (Instr !== q[0].instr || Err !== q[0].err) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h/%b want %h/%b", c, Instr, Err, q[0].instr, q[0].err); end
            if (!q[0].err) begin
               dec = m_decode(Instr, q[0].src);
               n_tests++; if (dec !== q[0].imm) begin n_fail++; $display("FAIL rnd_roundtrip[%0d]: decoded %h want %h", c, dec, q[0].imm); end
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_i_type();
      test_s_b();
      test_j_type();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
